// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the COREUART transmit scheduler.
// Used by the arbiter top and its round-robin picker.
package uart_tx_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WRITE    = 2'd1,
    ST_SETTLE   = 2'd2,
    ST_WAIT_RDY = 2'd3
  } state_t;

  localparam int DEF_NUM_REQ       = 4;
  localparam int DEF_SETTLE_CYCLES = 2;
  localparam int DEF_LOCK_TIMEOUT  = 255;
  localparam int STALL_W           = 16;
  localparam int SETTLE_W          = 4;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// Combinational round-robin picker: scans from ptr+1 upward, wrapping at
// NUM_REQ-1, and returns the first active request as one-hot plus index.
module uart_rr_pick
  import uart_tx_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int IW     = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [IW-1:0]      o_idx
);

  logic [IW:0]   w_sum;
  logic [IW-1:0] w_cand;
  logic          w_found;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    w_found  = 1'b0;
    w_sum    = '0;
    w_cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      // ptr < NUM_REQ and k <= NUM_REQ, so one subtraction is enough to wrap
      w_sum = {1'b0, i_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NUM_REQ)) begin
        w_sum = w_sum - (IW+1)'(NUM_REQ);
      end
      w_cand = w_sum[IW-1:0];
      if (!w_found && i_req[w_cand]) begin
        w_found          = 1'b1;
        o_idx            = w_cand;
        o_onehot[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one COREUART transmitter among NUM_REQ byte-stream requesters with
// round-robin packet-locked arbitration, write strobing and stall timeout.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int NUM_REQ       = DEF_NUM_REQ,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic [NUM_REQ-1:0]   o_abort,
  output logic                 o_busy,
  input  logic                 i_txrdy,
  output logic                 o_csn,
  output logic                 o_wen,
  output logic                 o_oen,
  output logic [7:0]           o_data_in
);

  localparam int IW = idx_w(NUM_REQ);

  state_t               r_state, w_state_next;
  logic [NUM_REQ-1:0]   r_grant, r_abort;
  logic [IW-1:0]        r_gidx, r_ptr;
  logic                 r_csn, r_wen, r_last;
  logic [7:0]           r_data;
  logic [SETTLE_W-1:0]  r_settle_cnt;
  logic [STALL_W-1:0]   r_stall_cnt;

  logic [7:0]           w_bytes [NUM_REQ];
  logic [NUM_REQ-1:0]   w_win_onehot;
  logic [IW-1:0]        w_win_idx;
  logic                 w_valid_g, w_last_g;
  logic                 w_start, w_accept, w_timeout, w_settle_done, w_done;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
    assign w_bytes[gi] = i_req_data[8*gi +: 8];
  end

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_req    (i_req_valid),
    .i_ptr    (r_ptr),
    .o_onehot (w_win_onehot),
    .o_idx    (w_win_idx)
  );

  assign w_valid_g     = i_req_valid[r_gidx];
  assign w_last_g      = i_req_last[r_gidx];
  assign w_start       = (r_state == ST_IDLE) && (|i_req_valid) && i_txrdy;
  assign w_accept      = (r_state == ST_WRITE) && w_valid_g && i_txrdy;
  assign w_timeout     = (r_state == ST_WRITE) && !w_valid_g &&
                         (r_stall_cnt == STALL_W'(LOCK_TIMEOUT - 1));
  assign w_settle_done = (r_state == ST_SETTLE) &&
                         (r_settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1));
  assign w_done        = (r_state == ST_WAIT_RDY) && i_txrdy && r_last;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:     if (w_start) w_state_next = ST_WRITE;
      ST_WRITE: begin
        if (w_accept)       w_state_next = ST_SETTLE;
        else if (w_timeout) w_state_next = ST_IDLE;
      end
      ST_SETTLE:   if (w_settle_done) w_state_next = ST_WAIT_RDY;
      ST_WAIT_RDY: if (i_txrdy) w_state_next = r_last ? ST_IDLE : ST_WRITE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = '0;
    if ((r_state == ST_WRITE) && i_txrdy) o_req_ready = r_grant & i_req_valid;
    o_busy = (r_state != ST_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_grant      <= '0;
      r_abort      <= '0;
      r_gidx       <= '0;
      r_ptr        <= IW'(NUM_REQ - 1);
      r_csn        <= 1'b1;
      r_wen        <= 1'b1;
      r_last       <= 1'b0;
      r_data       <= 8'h00;
      r_settle_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      // strobes are low only in the cycle right after a byte is accepted
      r_csn   <= !w_accept;
      r_wen   <= !w_accept;
      r_abort <= '0;
      if (w_start) begin
        r_grant     <= w_win_onehot;
        r_gidx      <= w_win_idx;
        r_stall_cnt <= '0;
      end
      if (w_accept) begin
        r_data       <= w_bytes[r_gidx];
        r_last       <= w_last_g;
        r_settle_cnt <= '0;
        r_stall_cnt  <= '0;
      end else if ((r_state == ST_WRITE) && !w_valid_g) begin
        if (w_timeout) begin
          r_abort     <= r_grant;
          r_grant     <= '0;
          r_ptr       <= r_gidx;
          r_stall_cnt <= '0;
        end else begin
          r_stall_cnt <= r_stall_cnt + STALL_W'(1);
        end
      end
      if (r_state == ST_SETTLE) r_settle_cnt <= r_settle_cnt + SETTLE_W'(1);
      if (w_done) begin
        r_grant <= '0;
        r_ptr   <= r_gidx;
      end
    end
  end

  assign o_grant   = r_grant;
  assign o_abort   = r_abort;
  assign o_csn     = r_csn;
  assign o_wen     = r_wen;
  assign o_oen     = 1'b1;
  assign o_data_in = r_data;

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter NUM_REQ, default 4: number of byte-stream requesters sharing one COREUART transmitter; range 2..8.
REQ-002 Parameter SETTLE_CYCLES, default 2: cycles waited after a write strobe before TXRDY is trusted; range 1..15.
REQ-003 Parameter LOCK_TIMEOUT, default 255: idle cycles allowed mid-packet before the grant is revoked; range 1..65535.
REQ-004 CLK  in  1  single clock, rising edge; all logic in this domain.
REQ-005 RESET  in  1  asynchronous, active-high reset.
REQ-006 REQ_VALID  in  NUM_REQ  per-requester byte valid.
REQ-007 REQ_DATA  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
REQ-008 REQ_LAST  in  NUM_REQ  marks the final byte of the requester's packet.
REQ-009 REQ_READY  out  NUM_REQ  byte-accept strobe; a byte transfers when VALID and READY are both high.
REQ-010 GRANT  out  NUM_REQ  one-hot owner of the UART; all-zero when idle.
REQ-011 ABORT  out  NUM_REQ  one-cycle pulse to a requester whose grant was revoked by timeout.
REQ-012 BUSY  out  1  high whenever the state is not IDLE.
REQ-013 TXRDY  in  1  transmitter-ready flag from COREUART.
REQ-014 CSN, WEN, OEN  out  1 each  active-low COREUART strobes; OEN is held at 1 permanently.
REQ-015 DATA_IN  out  8  byte presented to COREUART.

Function
REQ-016 The state machine has states IDLE, WRITE, SETTLE and WAIT_RDY.
REQ-017 IDLE, with any REQ_VALID high and TXRDY=1: a round-robin pick is made, starting at index (ptr+1) mod NUM_REQ.
  - GRANT is set one-hot to the winner on the next edge.
  - The state moves to WRITE.
REQ-018 The previous winner is stored in ptr; ptr is updated only when a packet ends or is aborted.
REQ-019 WRITE, with REQ_VALID[g]=1 and TXRDY=1 (g = granted index): REQ_READY[g] is asserted combinationally for that single cycle.
  - On the next edge DATA_IN <= REQ_DATA[g], CSN <= 0 and WEN <= 0.
  - The LAST flag is captured, the settle counter is cleared, and the state moves to SETTLE.
REQ-020 CSN and WEN are registered and are low for exactly one cycle: the first SETTLE cycle.
  - DATA_IN holds its value until the next write.
REQ-021 SETTLE lasts exactly SETTLE_CYCLES cycles; TXRDY is ignored throughout.
  - The state then moves to WAIT_RDY.
REQ-022 WAIT_RDY, with TXRDY=1: if the captured LAST=1, then GRANT <= 0, ptr <= g, and the state moves to IDLE.
  - Otherwise the state moves to WRITE with GRANT unchanged (packet lock).
REQ-023 WRITE with REQ_VALID[g]=0: a 16-bit stall counter increments.
  - When the count reaches LOCK_TIMEOUT, ABORT[g] pulses for one cycle, GRANT <= 0, ptr <= g, and the state moves to IDLE.
  - The stall counter clears on every accepted byte and on every grant.
REQ-024 REQ_READY is never asserted to any non-granted requester.
  - REQ_READY is never asserted outside WRITE.
  - REQ_READY is never asserted while TXRDY=0.
REQ-025 Any requester may hold VALID without being granted; a non-granted requester's data is ignored.
REQ-026 Fairness: a continuously requesting requester waits at most NUM_REQ-1 other packets.
REQ-027 Pointer wrap: after index NUM_REQ-1, the search continues at index 0.
REQ-028 Simultaneous VALID from all requesters in IDLE: exactly one GRANT bit is set.
REQ-029 A requester dropping VALID while not granted has no effect.
REQ-030 Single-byte packet (LAST on the first byte): the sequence is IDLE -> WRITE -> SETTLE -> WAIT_RDY -> IDLE.
REQ-031 Minimum per-byte period is 2 + SETTLE_CYCLES cycles: WRITE, SETTLE_CYCLES x SETTLE, and one WAIT_RDY cycle with TXRDY already high.
  - Real throughput is bounded by TXRDY.
REQ-032 TXRDY=0 in IDLE: no grant is issued; pending requests are held.

Reset
REQ-033 RESET high asynchronously forces:
  - state=IDLE;
  - CSN=1, WEN=1, OEN=1;
  - DATA_IN=0x00;
  - GRANT=0, ABORT=0, BUSY=0, REQ_READY=0;
  - ptr=NUM_REQ-1, so requester 0 wins first;
  - all counters = 0.
REQ-034 Reset asserted mid-packet abandons the packet silently (no ABORT pulse); the requester restarts the packet after reset.
REQ-035 Outputs leave reset values only on the first rising CLK edge after RESET deasserts.

Structure
REQ-036 A shared package holds:
  - the state enumeration;
  - default constants for NUM_REQ, SETTLE_CYCLES and LOCK_TIMEOUT;
  - the stall-counter width (16).
REQ-037 The round-robin search is one sub-module, uart_rr_pick.
  - Inputs: request vector and ptr.
  - Outputs: one-hot winner and winner index.
  - Purely combinational.

Verification
REQ-038 Reset, then REQ_VALID=0001, REQ_DATA[0]=0x5A, LAST=1, TXRDY=1 -> GRANT=0001; one CSN/WEN low cycle with DATA_IN=0x5A; BUSY returns to 0 after WAIT_RDY.
REQ-039 All four requesters valid with 1-byte packets, TXRDY=1 -> grants issued in order 0,1,2,3,0.
REQ-040 Requester 2 sends a 3-byte packet (0x11, 0x22, 0x33 with LAST) while requester 1 is valid -> three strobes with those bytes in order; requester 1 is granted only afterwards.
REQ-041 TXRDY held 0 for 20 cycles after a strobe -> no further REQ_READY or strobe until TXRDY=1.
REQ-042 LOCK_TIMEOUT=8; requester 0 sends one non-LAST byte, then drops VALID -> ABORT[0] pulses exactly 8 WRITE cycles later, GRANT=0, and requester 1 is served next.
REQ-043 RESET pulsed during SETTLE -> CSN=WEN=1 and GRANT=0 immediately; no ABORT; after release requester 0 wins first.
